// File: rtl/gpio_pkg.sv
// Shared register map and bus width for the GPIO peripheral.
// Edge interrupts are built only when GPIO_IRQ_EN is defined.
package gpio_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [4:0] OFF_OUT  = 5'h00;
  localparam logic [4:0] OFF_DIR  = 5'h04;
  localparam logic [4:0] OFF_IN   = 5'h08;
  localparam logic [4:0] OFF_SET  = 5'h0C;
  localparam logic [4:0] OFF_CLR  = 5'h10;
  localparam logic [4:0] OFF_MASK = 5'h14;
  localparam logic [4:0] OFF_STAT = 5'h18;

  typedef enum logic [2:0] {
    REG_OUT  = 3'd0,
    REG_DIR  = 3'd1,
    REG_IN   = 3'd2,
    REG_SET  = 3'd3,
    REG_CLR  = 3'd4,
    REG_MASK = 3'd5,
    REG_STAT = 3'd6,
    REG_RSVD = 3'd7
  } gpio_reg_e;

endpackage

// File: rtl/gpio_if.sv
// Core data bus as seen by the GPIO peripheral (active-low chip select, 1-cycle read).
interface gpio_if;
  import gpio_pkg::*;

  logic              cs;
  logic              we;
  logic [4:0]        addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;

  modport master (output cs, we, addr, wdata, input rdata, rvalid);
  modport slave  (input cs, we, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/gpio_sync.sv
// Per-pin input synchroniser: SYNC_STAGES flops, asynchronously reset to 0.
module gpio_sync #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_port.sv
// Memory-mapped GPIO: output/direction registers, atomic SET/CLR, synchronised input.
// Rising-edge interrupts (MASK/STAT/irq) are present only when GPIO_IRQ_EN is defined.
module gpio_port
  import gpio_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  gpio_if.slave            bus,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] pin_oe,
  output logic             irq
);

  gpio_reg_e         sel;
  logic              wr, rd;
  logic [WIDTH-1:0]  wdat;
  logic [WIDTH-1:0]  in_sync;
  logic [WIDTH-1:0]  out_q, out_d, dir_q, dir_d;
  logic [WIDTH-1:0]  mask_rd, stat_rd;
  logic [WIDTH-1:0]  rmux;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic              unused_bus;

  assign sel  = gpio_reg_e'(bus.addr[4:2]);
  assign wr   = !bus.cs && bus.we;
  assign rd   = !bus.cs && !bus.we;
  assign wdat = bus.wdata[WIDTH-1:0];

  // Whole-word reduction marks the ignored upper data and byte-lane bits as intentionally unused.
  assign unused_bus = ^{bus.wdata, bus.addr[1:0]};

  gpio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pin_in),
    .q     (in_sync)
  );

  always_comb begin
    out_d = out_q;
    dir_d = dir_q;
    if (wr) begin
      case (sel)
        REG_OUT: out_d = wdat;
        REG_DIR: dir_d = wdat;
        REG_SET: out_d = out_q | wdat;
        REG_CLR: out_d = out_q & ~wdat;
        default: ;
      endcase
    end
  end

`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] prev_q, mask_q, mask_d, stat_q, stat_d;
  logic             irq_q;

  always_comb begin
    mask_d = mask_q;
    stat_d = stat_q;
    if (wr && sel == REG_MASK) mask_d = wdat;
    if (wr && sel == REG_STAT) stat_d = stat_q & ~wdat;
    // Applied after the W1C so a same-cycle rising edge wins.
    stat_d = stat_d | (in_sync & ~prev_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      mask_q <= '0;
      stat_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      prev_q <= in_sync;
      mask_q <= mask_d;
      stat_q <= stat_d;
      irq_q  <= |(stat_q & mask_q);
    end
  end

  assign mask_rd = mask_q;
  assign stat_rd = stat_q;
  assign irq     = irq_q;
`else
  assign mask_rd = '0;
  assign stat_rd = '0;
  assign irq     = 1'b0;
`endif

  always_comb begin
    rmux = '0;
    case (sel)
      REG_OUT:  rmux = out_q;
      REG_DIR:  rmux = dir_q;
      REG_IN:   rmux = in_sync;
      REG_MASK: rmux = mask_rd;
      REG_STAT: rmux = stat_rd;
      default:  rmux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= '0;
      dir_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      dir_q    <= dir_d;
      rdata_q  <= rd ? DATA_W'(rmux) : '0;
      rvalid_q <= rd;
    end
  end

  assign pin_out    = out_q;
  assign pin_oe     = dir_q;
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;

endmodule

// File: tb/tb_gpio_port.sv
// Randomised self-checking bench for gpio_port against a transaction-level register model.
module tb_gpio_port;
  import gpio_pkg::*;

  localparam int unsigned SYNC = 2;
`ifdef GPIO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pin_in, pin_out, pin_oe;
  logic       irq;
  int         checks = 0;
  int         errors = 0;

  gpio_if bus ();

  gpio_port #(
    .WIDTH       (8),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .pin_in  (pin_in),
    .pin_out (pin_out),
    .pin_oe  (pin_oe),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // Reference model state: register file plus a pad-history queue standing in for the synchroniser.
  logic [7:0]  m_out, m_dir, m_mask, m_stat, m_prev;
  logic        m_irq, m_rvalid;
  logic [31:0] m_rdata;
  logic [7:0]  pin_hist[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out = 0; m_dir = 0; m_mask = 0; m_stat = 0; m_prev = 0;
    m_irq = 0; m_rvalid = 0; m_rdata = 0;
    pin_hist = {};
    for (int i = 0; i < SYNC; i++) pin_hist.push_back(8'h00);
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "_pin_out"}, {24'h0, pin_out}, {24'h0, m_out});
    check({pfx, "_pin_oe"},  {24'h0, pin_oe},  {24'h0, m_dir});
    check({pfx, "_rvalid"},  {31'h0, bus.rvalid}, {31'h0, m_rvalid});
    check({pfx, "_rdata"},   bus.rdata, m_rdata);
    check({pfx, "_irq"},     {31'h0, irq}, {31'h0, m_irq});
  endtask

  // One clock: advance the model from the pre-edge inputs, then compare just after the edge.
  task automatic tick();
    logic       wr, rd;
    logic [2:0] sel;
    logic [7:0] w, cur_in, rmux, w1c;
    wr     = !bus.cs && bus.we;
    rd     = !bus.cs && !bus.we;
    sel    = bus.addr[4:2];
    w      = bus.wdata[7:0];
    cur_in = pin_hist[0];
    case (sel)
      3'd0:    rmux = m_out;
      3'd1:    rmux = m_dir;
      3'd2:    rmux = cur_in;
      3'd5:    rmux = IRQ_EN ? m_mask : 8'h00;
      3'd6:    rmux = IRQ_EN ? m_stat : 8'h00;
      default: rmux = 8'h00;
    endcase
    m_rdata  = rd ? {24'h0, rmux} : 32'h0;
    m_rvalid = rd;
    m_irq    = IRQ_EN && ((m_stat & m_mask) != 0);
    if (IRQ_EN) begin
      w1c    = (wr && sel == 3'd6) ? w : 8'h00;
      m_stat = (m_stat & ~w1c) | (cur_in & ~m_prev);
      m_prev = cur_in;
      if (wr && sel == 3'd5) m_mask = w;
    end
    if (wr) begin
      case (sel)
        3'd0: m_out = w;
        3'd1: m_dir = w;
        3'd3: m_out = m_out | w;
        3'd4: m_out = m_out & ~w;
        default: ;
      endcase
    end
    pin_hist.push_back(pin_in);
    if (pin_hist.size() > SYNC) void'(pin_hist.pop_front());
    @(posedge clk);
    #1;
    check_outputs("cyc");
  endtask

  task automatic idle();
    bus.cs = 1'b1; bus.we = 1'b0; bus.addr = 5'h00; bus.wdata = 32'h0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    bus.cs = 1'b0; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
    tick();
    idle();
  endtask

  task automatic do_read(input logic [4:0] a, output logic [31:0] d);
    bus.cs = 1'b0; bus.we = 1'b0; bus.addr = a; bus.wdata = $urandom;
    tick();
    d = bus.rdata;
    check("read_rvalid", {31'h0, bus.rvalid}, 32'h1);
    idle();
  endtask

  logic [31:0] rd_val;

  initial begin
    rst_n = 1'b0; pin_in = 8'h00;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Reset asserted in the middle of a write of OUT
    do_write(OFF_DIR, 32'h33);
    bus.cs = 1'b0; bus.we = 1'b1; bus.addr = OFF_OUT; bus.wdata = 32'hFF;
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_pin_out", {24'h0, pin_out}, 32'h0);
    check("rst_pin_oe",  {24'h0, pin_oe},  32'h0);
    check("rst_rdata",   bus.rdata, 32'h0);
    check("rst_irq",     {31'h0, irq}, 32'h0);
    repeat (2) @(posedge clk);
    #2 idle();
    rst_n = 1'b1;

    // OUT/DIR write and readback
    do_write(OFF_OUT, 32'hA5);
    do_write(OFF_DIR, 32'h0F);
    check("t2_pin_out", {24'h0, pin_out}, 32'hA5);
    check("t2_pin_oe",  {24'h0, pin_oe},  32'h0F);
    do_read(OFF_OUT, rd_val); check("t2_rd_out", rd_val, 32'hA5);
    do_read(OFF_DIR, rd_val); check("t2_rd_dir", rd_val, 32'h0F);
    tick();
    check("t2_rvalid_drop", {31'h0, bus.rvalid}, 32'h0);

    // SET/CLR and upper-bit masking
    do_write(OFF_OUT, 32'hF0);
    do_write(OFF_SET, 32'h03); check("t3_set", {24'h0, pin_out}, 32'hF3);
    do_write(OFF_CLR, 32'h30); check("t3_clr", {24'h0, pin_out}, 32'hC3);
    do_write(OFF_OUT, 32'hFFFF_FF00); check("t3_wide", {24'h0, pin_out}, 32'h00);
    do_read(OFF_OUT, rd_val); check("t3_rd_out", rd_val, 32'h0);

    // Input synchroniser latency, read-only IN, zero-reading offsets
    pin_in = 8'h5A;
    do_read(OFF_IN, rd_val); check("t4_in_0", rd_val, 32'h00);
    do_read(OFF_IN, rd_val); check("t4_in_1", rd_val, 32'h00);
    do_read(OFF_IN, rd_val); check("t4_in_2", rd_val, 32'h5A);
    do_write(OFF_IN, 32'h77);
    do_write(5'h1C, 32'hFF);
    check("t4_wr_ignored", {24'h0, pin_out}, 32'h00);
    do_read(OFF_IN,  rd_val); check("t4_in_keep", rd_val, 32'h5A);
    do_read(OFF_SET, rd_val); check("t4_rd_set",  rd_val, 32'h0);
    do_read(OFF_CLR, rd_val); check("t4_rd_clr",  rd_val, 32'h0);
    do_read(5'h1C,   rd_val); check("t4_rd_1c",   rd_val, 32'h0);

    // Edge interrupt, W1C, and rise colliding with W1C
    pin_in = 8'h00;
    repeat (SYNC + 2) tick();
    do_write(OFF_STAT, 32'hFF);
    do_write(OFF_MASK, 32'h01);
    pin_in = 8'h01;
    repeat (SYNC + 2) tick();
    check("t5_irq_set", {31'h0, irq}, {31'h0, IRQ_EN});
    do_read(OFF_STAT, rd_val); check("t5_stat", rd_val, IRQ_EN ? 32'h01 : 32'h0);
    do_read(OFF_MASK, rd_val); check("t5_mask", rd_val, IRQ_EN ? 32'h01 : 32'h0);
    do_write(OFF_STAT, 32'h01);
    tick();
    check("t5_irq_clr", {31'h0, irq}, 32'h0);
    pin_in = 8'h00;
    repeat (SYNC + 2) tick();
    pin_in = 8'h01;
    repeat (SYNC) tick();
    do_write(OFF_STAT, 32'h01);
    do_read(OFF_STAT, rd_val); check("t5_set_wins", rd_val, IRQ_EN ? 32'h01 : 32'h0);

    // Random traffic, including back-to-back reads and pad changes
    for (int i = 0; i < 400; i++) begin
      bus.cs    = ($urandom_range(0, 3) == 0);
      bus.we    = $urandom_range(0, 1) == 1;
      bus.addr  = 5'($urandom_range(0, 31));
      bus.wdata = $urandom;
      if ($urandom_range(0, 3) == 0) pin_in = 8'($urandom);
      tick();
    end
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
